// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must be able to represent 0..WIDTH.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor cell: diff = x - y - bi, with borrow-out.
module oneBitSubtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic diff,
   output logic bo
);

   assign diff = x ^ y ^ bi;
   assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy
`ifdef SERIAL_SUB_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] d_sh_q,   d_sh_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             cell_diff;
   logic             cell_bo;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   oneBitSubtractor u_cell (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bi   (borrow_q),
      .diff (cell_diff),
      .bo   (cell_bo)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      d_sh_d   = d_sh_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            // Diff bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
            d_sh_d   = {cell_diff, d_sh_q[WIDTH-1:1]};
            borrow_d = cell_bo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
               // Borrow into the MSB differs from borrow out of it on signed overflow.
               ovf_d   = borrow_q ^ cell_bo;
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         d_sh_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         d_sh_q   <= d_sh_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign d         = d_sh_q;
   assign bout      = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4); ovf checks when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] d;
   logic         bout;
   logic         busy;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Drives one accept and waits (bounded) for out_valid; leaves the bench at a
   // negedge with the result held (out_ready low). lat = posedges from accept.
   task automatic start_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi, input bit disturb, output int lat);
      @(negedge clk);
      a = av; b = bv; bin = bi; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (disturb) begin
         in_valid = 1'b1; a = ~av; b = ~bv; bin = ~bi;
      end
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (d !== 4'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", d); end
      checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] va [5] = '{4'h9, 4'h3, 4'h0, 4'h7, 4'hF};
      logic [W-1:0] vb [5] = '{4'h3, 4'h9, 4'h0, 4'h7, 4'h0};
      logic         vi [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] ed [5] = '{4'h6, 4'hA, 4'hF, 4'hF, 4'hF};
      logic         eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         start_and_wait(va[i], vb[i], vi[i], 1'b0, lat);
         checks++; if (lat !== W) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, W); end
         checks++; if (d !== ed[i]) begin failures++; $display("FAIL basic_d[%0d] got=%h exp=%h", i, d, ed[i]); end
         checks++; if (bout !== eb[i]) begin failures++; $display("FAIL basic_bout[%0d] got=%b exp=%b", i, bout, eb[i]); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got=%b exp=1", i, busy); end
         handshake();
         checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_release[%0d] in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
         end
      end
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      int lat;
      start_and_wait(4'h8, 4'h1, 1'b0, 1'b0, lat);
      checks++; if (d !== 4'h7 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_8m1 d=%h ovf=%b exp 7/1", d, ovf); end
      handshake();
      start_and_wait(4'h5, 4'h2, 1'b0, 1'b0, lat);
      checks++; if (d !== 4'h3 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_5m2 d=%h ovf=%b exp 3/0", d, ovf); end
      handshake();
   endtask
`endif

   task automatic test_backpressure();
      int lat;
      start_and_wait(4'h6, 4'h2, 1'b0, 1'b1, lat);
      checks++; if (lat !== W) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, W); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (d !== 4'h4 || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d] d=%h bout=%b out_valid=%b in_ready=%b exp 4/0/1/0", k, d, bout, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      handshake();
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      a = 4'h9; b = 4'h3; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 4'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset in_ready=%b out_valid=%b d=%h busy=%b exp 1/0/0/0", in_ready, out_valid, d, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_and_wait(4'h7, 4'h2, 1'b0, 1'b0, lat);
      checks++; if (d !== 4'h5 || bout !== 1'b0 || lat !== W) begin
         failures++; $display("FAIL midreset_next d=%h bout=%b lat=%0d exp 5/0/%0d", d, bout, lat, W);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] va [3] = '{4'h9, 4'h2, 4'hF};
      logic [W-1:0] vb [3] = '{4'h3, 4'h5, 4'hF};
      logic         vi [3] = '{1'b0, 1'b1, 1'b0};
      logic [W-1:0] ed [3] = '{4'h6, 4'hC, 4'h0};
      logic         eb [3] = '{1'b0, 1'b1, 1'b0};
      int acc_cyc [3];
      int acc = 0;
      int res = 0;
      int cyc = 0;
      out_ready = 1'b1;
      while (res < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            checks++; if (d !== ed[res] || bout !== eb[res]) begin
               failures++; $display("FAIL b2b_result[%0d] d=%h bout=%b exp %h/%b", res, d, bout, ed[res], eb[res]);
            end
            res++;
         end
         if (in_ready) begin
            if (acc < 3) begin
               a = va[acc]; b = vb[acc]; bin = vi[acc]; in_valid = 1'b1;
               acc_cyc[acc] = cyc;
               acc++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (res !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", res); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (acc_cyc[i+1] - acc_cyc[i] !== W + 2) begin
            failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, acc_cyc[i+1] - acc_cyc[i], W + 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
